// File: rtl/spm_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : spm_seq_ctrl_if
//  Description : Wishbone classic slave bus bundle for the SPM sequencer.
//                The master modport drives the request side, the slave
//                modport returns read data and acknowledge.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spm_seq_ctrl_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
        input  wbs_dat_o, wbs_ack_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
        output wbs_dat_o, wbs_ack_o
    );
endinterface
`default_nettype wire

// File: rtl/spm_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spm_seq_ctrl
//  Description : Wishbone-controlled sequencer for a serial/parallel
//                multiplier core. Holds operands, starts the core, waits for
//                completion with a timeout, and captures the 64-bit product
//                one 32-bit half at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module spm_seq_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  wire logic        clk,
    input  wire logic        rst,
    spm_seq_ctrl_if.slave    wbs,
    output logic [31:0]      spm_mc,
    output logic [31:0]      spm_mp,
    output logic             spm_start,
    output logic             spm_prod_sel,
    input  wire logic [31:0] spm_prod,
    input  wire logic        spm_done,
    output logic             irq
);
    localparam logic [2:0]  c_S_IDLE    = 3'd0;
    localparam logic [2:0]  c_S_RUN     = 3'd1;
    localparam logic [2:0]  c_S_WAIT    = 3'd2;
    localparam logic [2:0]  c_S_CAP_LO  = 3'd3;
    localparam logic [2:0]  c_S_CAP_HI  = 3'd4;

    localparam logic [2:0]  c_A_MC      = 3'd0;
    localparam logic [2:0]  c_A_MP      = 3'd1;
    localparam logic [2:0]  c_A_CTRL    = 3'd2;
    localparam logic [2:0]  c_A_STATUS  = 3'd3;
    localparam logic [2:0]  c_A_PROD_LO = 3'd4;
    localparam logic [2:0]  c_A_PROD_HI = 3'd5;

    // Last WAIT counter value before the wait is abandoned.
    localparam logic [15:0] c_WAIT_LAST = 16'(TIMEOUT - 1);

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q;
    logic [31:0] mc_q, mp_q, prod_lo_q, prod_hi_q, dat_q;
    logic        ack_q, irq_en_q, done_q, tmo_q;

    logic [31:0] w_rdata;
    logic [2:0]  w_adr;
    logic        w_busy, w_req, w_wr, w_start_acc, w_wait_exp, w_w1c_done, w_w1c_tmo;
    logic        w_unused_adr;

    assign w_adr        = wbs.wbs_adr_i[4:2];
    assign w_unused_adr = ^{wbs.wbs_adr_i[31:5], wbs.wbs_adr_i[1:0]};
    assign w_busy       = (state_q != c_S_IDLE);
    // New request: cycle seen while ack is low; ack follows next cycle.
    assign w_req        = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q;
    // Writes commit at the end of the ack cycle so START lands RUN one cycle later.
    assign w_wr         = ack_q & wbs.wbs_cyc_i & wbs.wbs_stb_i & wbs.wbs_we_i;
    assign w_start_acc  = w_wr && (w_adr == c_A_CTRL) && wbs.wbs_dat_i[0] && !w_busy;
    // spm_done on the final WAIT cycle takes priority over the timeout.
    assign w_wait_exp   = (state_q == c_S_WAIT) && !spm_done && (cnt_q == c_WAIT_LAST);
    assign w_w1c_done   = w_wr && (w_adr == c_A_STATUS) && wbs.wbs_dat_i[1];
    assign w_w1c_tmo    = w_wr && (w_adr == c_A_STATUS) && wbs.wbs_dat_i[2];

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign spm_mc        = mc_q;
    assign spm_mp        = mp_q;
    assign irq           = irq_en_q & (done_q | tmo_q);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= c_S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic for the start / wait / two-step capture sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_S_IDLE:   if (w_start_acc) state_d = c_S_RUN;
            c_S_RUN:    state_d = c_S_WAIT;
            c_S_WAIT: begin
                if (spm_done)        state_d = c_S_CAP_LO;
                else if (w_wait_exp) state_d = c_S_IDLE;
            end
            c_S_CAP_LO: state_d = c_S_CAP_HI;
            c_S_CAP_HI: state_d = c_S_IDLE;
            default:    state_d = c_S_IDLE;
        endcase
    end

    // Core-facing strobes decoded from the current state.
    always_comb begin
        spm_start    = (state_q == c_S_RUN);
        spm_prod_sel = (state_q == c_S_CAP_HI);
    end

    // Register read multiplexer.
    always_comb begin
        w_rdata = '0;
        case (w_adr)
            c_A_MC:      w_rdata = mc_q;
            c_A_MP:      w_rdata = mp_q;
            c_A_CTRL:    w_rdata = {30'd0, irq_en_q, 1'b0};
            c_A_STATUS:  w_rdata = {29'd0, tmo_q, done_q, w_busy};
            c_A_PROD_LO: w_rdata = prod_lo_q;
            c_A_PROD_HI: w_rdata = prod_hi_q;
            default:     w_rdata = '0;
        endcase
    end

    // Bus acknowledge and read data, valid only during the ack cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= w_req;
            dat_q <= w_req ? w_rdata : '0;
        end
    end

    // Operand registers: byte-lane writes, frozen while an operation runs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mc_q <= '0;
            mp_q <= '0;
        end else if (w_wr && !w_busy) begin
            for (int b = 0; b < 4; b++) begin
                if (wbs.wbs_sel_i[b] && (w_adr == c_A_MC)) mc_q[8*b +: 8] <= wbs.wbs_dat_i[8*b +: 8];
                if (wbs.wbs_sel_i[b] && (w_adr == c_A_MP)) mp_q[8*b +: 8] <= wbs.wbs_dat_i[8*b +: 8];
            end
        end
    end

    // Control and sticky status flags; FSM set beats a same-cycle w1c.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            if (w_wr && (w_adr == c_A_CTRL)) irq_en_q <= wbs.wbs_dat_i[1];

            if (state_q == c_S_CAP_HI) done_q <= 1'b1;
            else if (w_start_acc)      done_q <= 1'b0;
            else if (w_w1c_done)       done_q <= 1'b0;

            if (w_wait_exp)            tmo_q <= 1'b1;
            else if (w_start_acc)      tmo_q <= 1'b0;
            else if (w_w1c_tmo)        tmo_q <= 1'b0;
        end
    end

    // WAIT cycle counter and product capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            prod_lo_q <= '0;
            prod_hi_q <= '0;
        end else begin
            cnt_q <= (state_q == c_S_WAIT) ? cnt_q + 16'd1 : 16'd0;
            if (state_q == c_S_CAP_LO) prod_lo_q <= spm_prod;
            if (state_q == c_S_CAP_HI) prod_hi_q <= spm_prod;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_spm_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spm_seq_ctrl
//  Description : Scoreboard bench for spm_seq_ctrl with a multiplier core
//                model and a register-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spm_seq_ctrl;
    localparam int c_TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spm_seq_ctrl_if wbs();
    logic [31:0] spm_mc, spm_mp, spm_prod;
    logic        spm_start, spm_prod_sel, spm_done, irq;

    spm_seq_ctrl #(.TIMEOUT(c_TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .wbs          (wbs),
        .spm_mc       (spm_mc),
        .spm_mp       (spm_mp),
        .spm_start    (spm_start),
        .spm_prod_sel (spm_prod_sel),
        .spm_prod     (spm_prod),
        .spm_done     (spm_done),
        .irq          (irq)
    );

    // Multiplier core model: done rises core_delay cycles after the start pulse.
    logic [63:0] core_full;
    int          core_cnt;
    logic        core_act;
    int          core_delay;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_act  <= 1'b0;
            core_cnt  <= 0;
            core_full <= '0;
        end else if (spm_start) begin
            core_act  <= 1'b1;
            core_cnt  <= 1;
            core_full <= 64'(spm_mc) * 64'(spm_mp);
        end else if (core_act) begin
            core_cnt <= core_cnt + 1;
        end
    end
    assign spm_done = core_act && (core_cnt >= core_delay);
    assign spm_prod = spm_prod_sel ? core_full[63:32] : core_full[31:0];

    // Scoreboard and counters.
    typedef struct { bit chk; logic [31:0] exp; string name; } sb_t;
    sb_t sb_q[$];
    sb_t mon_it;
    int  n_tests = 0, n_fail = 0;
    int  cyc_n = 0;
    int  start_cnt = 0, start_cyc = 0, psel_cnt = 0, psel_cyc = 0, irq_rise_cyc = 0;
    logic prev_ack = 1'b0, prev_irq = 1'b0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Monitor: pops the expected response on every ack, tracks core strobes.
    always @(negedge clk) begin
        if (rst) begin
            prev_ack = 1'b0;
            prev_irq = 1'b0;
        end else begin
            if (wbs.wbs_ack_o) begin
                n_tests++;
                if (prev_ack) begin
                    n_fail++;
                    $display("FAIL ack_single: ack high on consecutive cycles at cycle %0d", cyc_n);
                end
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL ack_unexpected: ack with no outstanding transfer at cycle %0d", cyc_n);
                end else begin
                    mon_it = sb_q.pop_front();
                    if (mon_it.chk) begin
                        n_tests++;
                        if (wbs.wbs_dat_o !== mon_it.exp) begin
                            n_fail++;
                            $display("FAIL %s: got 0x%08h expected 0x%08h", mon_it.name, wbs.wbs_dat_o, mon_it.exp);
                        end
                    end
                end
            end
            if (spm_start)    begin start_cnt++; start_cyc = cyc_n; end
            if (spm_prod_sel) begin psel_cnt++;  psel_cyc  = cyc_n; end
            if (irq && !prev_irq) irq_rise_cyc = cyc_n;
            prev_ack = wbs.wbs_ack_o;
            prev_irq = irq;
        end
    end

    // Reference model state.
    logic [31:0] m_mc, m_mp, m_lo, m_hi;
    logic        m_ien, m_done, m_tmo;
    int          op_d, s_base, p_base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~m) | (n & m);
    endfunction

    task automatic wb_xfer(input bit we, input logic [2:0] a, input logic [31:0] d, input logic [3:0] sel,
                           input bit chk, input logic [31:0] exp, input string name, output int ack_cyc);
        sb_t it;
        logic [31:0] r;
        it.chk = chk; it.exp = exp; it.name = name;
        sb_q.push_back(it);
        r = $urandom();
        @(posedge clk); #1;
        wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1; wbs.wbs_we_i = we;
        wbs.wbs_adr_i = {r[31:5], a, r[1:0]};
        wbs.wbs_dat_i = d; wbs.wbs_sel_i = sel;
        ack_cyc = -1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (wbs.wbs_ack_o) begin ack_cyc = cyc_n; break; end
        end
        if (ack_cyc < 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s: no ack within 8 cycles", name);
            if (sb_q.size() > 0) it = sb_q.pop_back();
        end
        @(posedge clk); #1;
        wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0; wbs.wbs_we_i = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] sel);
        int ac;
        wb_xfer(1'b1, a, d, sel, 1'b0, 32'd0, "wr", ac);
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
        int ac;
        wb_xfer(1'b0, a, 32'd0, 4'($urandom_range(0, 15)), 1'b1, exp, name, ac);
    endtask

    task automatic read_all();
        rd(3'd0, m_mc, "rd_mc");
        rd(3'd1, m_mp, "rd_mp");
        rd(3'd2, {30'd0, m_ien, 1'b0}, "rd_ctrl");
        rd(3'd3, {29'd0, m_tmo, m_done, 1'b0}, "rd_status");
        rd(3'd4, m_lo, "rd_prod_lo");
        rd(3'd5, m_hi, "rd_prod_hi");
        rd(3'd6, 32'd0, "rd_adr6");
        rd(3'd7, 32'd0, "rd_adr7");
    endtask

    task automatic start_op(input logic [31:0] mc, input logic [31:0] mp, input logic [3:0] sel,
                            input int d, input logic ien);
        int a;
        wr(3'd0, mc, sel);  m_mc = merge(m_mc, mc, sel);
        wr(3'd1, mp, 4'hF); m_mp = mp;
        core_delay = d; op_d = d;
        s_base = start_cnt; p_base = psel_cnt;
        // sel = 0 on CTRL: the write must still take the full word.
        wb_xfer(1'b1, 3'd2, {30'd0, ien, 1'b1}, 4'h0, 1'b0, 32'd0, "wr_start", a);
        m_ien = ien; m_done = 1'b0; m_tmo = 1'b0;
        repeat (2) @(negedge clk);
        check("start_latency", 32'(start_cyc - a), 32'd1);
        check("spm_mc", spm_mc, m_mc);
        check("spm_mp", spm_mp, m_mp);
    endtask

    task automatic finish_op();
        bit          exp_done;
        logic [63:0] prod;
        int          lim;
        exp_done = (op_d <= c_TMO);
        prod     = 64'(m_mc) * 64'(m_mp);
        if (m_ien) begin
            lim = 0;
            while (irq_rise_cyc <= start_cyc && lim < 100) begin @(negedge clk); lim++; end
            check("irq_latency", 32'(irq_rise_cyc - start_cyc), exp_done ? 32'(op_d + 3) : 32'(c_TMO + 1));
        end else begin
            repeat (c_TMO + 8) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check("start_pulses", 32'(start_cnt - s_base), 32'd1);
        check("prod_sel_cycles", 32'(psel_cnt - p_base), 32'(exp_done));
        if (exp_done) check("prod_sel_timing", 32'(psel_cyc - start_cyc), 32'(op_d + 2));
        if (exp_done) begin m_done = 1'b1; m_lo = prod[31:0]; m_hi = prod[63:32]; end
        else          m_tmo = 1'b1;
        check("irq_level", 32'(irq), 32'(m_ien & (m_done | m_tmo)));
        read_all();
        wr(3'd3, {29'd0, m_tmo, m_done, 1'b0}, 4'($urandom_range(0, 15)));
        m_done = 1'b0; m_tmo = 1'b0;
        check("irq_after_w1c", 32'(irq), 32'd0);
        rd(3'd3, 32'd0, "rd_status_cleared");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lim;
        wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0; wbs.wbs_we_i = 1'b0;
        wbs.wbs_adr_i = '0;   wbs.wbs_dat_i = '0;   wbs.wbs_sel_i = '0;
        core_delay = 1000;
        m_mc = '0; m_mp = '0; m_lo = '0; m_hi = '0; m_ien = 1'b0; m_done = 1'b0; m_tmo = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ack", 32'(wbs.wbs_ack_o), 32'd0);
        check("rst_dat", wbs.wbs_dat_o, 32'd0);
        check("rst_start", 32'(spm_start), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rst = 1'b0;
        read_all();

        // Byte-lane write onto a zero MC.
        wr(3'd0, 32'hAABBCCDD, 4'b0101); m_mc = merge(m_mc, 32'hAABBCCDD, 4'b0101);
        rd(3'd0, 32'h00BB00DD, "rd_mc_bytelanes");
        check("spm_mc_bytelanes", spm_mc, 32'h00BB00DD);
        wr(3'd6, $urandom(), 4'hF);
        rd(3'd6, 32'd0, "rd_adr6_after_write");

        // Small product.
        start_op(32'd5, 32'd7, 4'hF, 10, 1'b1);
        finish_op();
        rd(3'd4, 32'd35, "rd_prod_lo_35");

        // Max operands, done on the last WAIT cycle, writes while busy.
        start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 4'hF, c_TMO, 1'b0);
        wr(3'd0, 32'h00001234, 4'hF);
        wr(3'd2, 32'h00000001, 4'hF);
        rd(3'd3, 32'h00000001, "rd_status_busy");
        rd(3'd4, m_lo, "rd_prod_lo_busy");
        check("spm_mc_busy_write", spm_mc, m_mc);
        finish_op();
        rd(3'd4, 32'h00000001, "rd_prod_lo_max");
        rd(3'd5, 32'hFFFFFFFE, "rd_prod_hi_max");

        // Timeout: one cycle past the limit.
        start_op($urandom(), $urandom(), 4'hF, c_TMO + 1, 1'b1);
        rd(3'd5, m_hi, "rd_prod_hi_busy");
        finish_op();

        // Timeout with done never raised.
        start_op($urandom(), $urandom(), 4'hF, 1000, 1'b1);
        finish_op();

        // STATUS w1c committing on the CAP_HI cycle: DONE set must win.
        start_op(32'd3, 32'd9, 4'hF, 10, 1'b1);
        lim = 0;
        while (cyc_n < start_cyc + 10 && lim < 50) begin @(negedge clk); lim++; end
        wr(3'd3, 32'h00000006, 4'hF);
        finish_op();

        // Randomized operations.
        for (int i = 0; i < 8; i++) begin
            start_op($urandom(), $urandom(), 4'($urandom_range(0, 15)),
                     int'($urandom_range(1, 22)), 1'($urandom_range(0, 3) != 0));
            finish_op();
        end

        // Reset in WAIT: immediate clear, no capture, clean restart.
        start_op($urandom() | 32'h1, $urandom() | 32'h1, 4'hF, 1000, 1'b1);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_spm_mc", spm_mc, 32'd0);
        check("arst_spm_start", 32'(spm_start), 32'd0);
        check("arst_prod_sel", 32'(spm_prod_sel), 32'd0);
        check("arst_irq", 32'(irq), 32'd0);
        check("arst_ack", 32'(wbs.wbs_ack_o), 32'd0);
        check("arst_dat", wbs.wbs_dat_o, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_mc = '0; m_mp = '0; m_lo = '0; m_hi = '0; m_ien = 1'b0; m_done = 1'b0; m_tmo = 1'b0;
        read_all();
        start_op(32'd11, 32'd13, 4'hF, 5, 1'b1);
        finish_op();

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/spm_seq_ctrl.md
SPM_SEQ_CTRL -- requirements
Module: spm_seq_ctrl

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 255, max WAIT-state cycles before abort (1..65535).
REQ-002 SHALL provide port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide wbs_cyc_i / wbs_stb_i / wbs_we_i  input  1 each  Wishbone slave cycle, strobe, write-enable.
REQ-005 SHALL provide wbs_adr_i  input  32  byte address; only bits [4:2] decoded.
REQ-006 SHALL provide wbs_dat_i  input  32 and wbs_sel_i  input  4  write data, byte lanes.
REQ-007 SHALL provide wbs_dat_o  output  32 and wbs_ack_o  output  1  read data, acknowledge.
REQ-008 SHALL provide spm_mc, spm_mp  output  32 each  multiplicand, multiplier to the SPM core.
REQ-009 SHALL provide spm_start  output  1, spm_prod_sel  output  1 (0 = low word, 1 = high word).
REQ-010 SHALL provide spm_prod  input  32 and spm_done  input  1  product half, core completion.
REQ-011 SHALL provide irq  output  1  level interrupt.

Function
REQ-012 Register map (adr[4:2]) SHALL be: 0 MC rw, 1 MP rw, 2 CTRL (bit0 START w/read-0, bit1 IRQ_EN rw), 3 STATUS (bit0 BUSY ro, bit1 DONE w1c, bit2 TMO w1c), 4 PROD_LO ro, 5 PROD_HI ro; 6-7 read 0, writes ignored.
REQ-013 Ack SHALL assert exactly one cycle, the cycle after cyc&stb is first seen with ack low; ack SHALL be low the following cycle (no back-to-back acks); register update/read data take effect on the ack cycle.
REQ-014 MC/MP writes SHALL honour wbs_sel_i per byte; CTRL/STATUS writes SHALL use full word regardless of sel.
REQ-015 MC/MP writes and START=1 while BUSY SHALL be acked and ignored.
REQ-016 spm_mc/spm_mp SHALL be driven directly from MC/MP registers.
REQ-017 FSM states SHALL be IDLE, RUN, WAIT, CAP_LO, CAP_HI.
REQ-018 IDLE->RUN on accepted START=1 write (ack cycle A); RUN in cycle A+1 with spm_start=1 for exactly that cycle; BUSY=1 from A+1; DONE and TMO cleared on entry to RUN.
REQ-019 RUN->WAIT unconditionally; WAIT counter SHALL start at 0 and increment each WAIT cycle.
REQ-020 WAIT->CAP_LO when spm_done=1; WAIT->IDLE with TMO=1 when counter reaches TIMEOUT-1 and spm_done=0; spm_done=1 on that same cycle SHALL win (go CAP_LO, no TMO).
REQ-021 CAP_LO: spm_prod_sel=0, PROD_LO <= spm_prod at cycle end; CAP_HI: spm_prod_sel=1, PROD_HI <= spm_prod; CAP_HI->IDLE setting DONE=1, BUSY=0.
REQ-022 spm_prod_sel SHALL be 0 in every state except CAP_HI.
REQ-023 On timeout PROD_LO/PROD_HI SHALL retain previous values.
REQ-024 irq SHALL equal IRQ_EN & (DONE | TMO), registered-free combinational from state bits.
REQ-025 w1c write to STATUS in same cycle DONE is set by FSM: set SHALL win.
REQ-026 Reads of PROD_* while BUSY SHALL return previous result.

Reset
REQ-027 rst=1 SHALL immediately force: state IDLE, all registers, counter, wbs_ack_o, wbs_dat_o, spm_start, spm_prod_sel, irq to 0; asserting mid-operation SHALL abort with no result capture.
REQ-028 After rst deasserts, first Wishbone cycle SHALL be accepted normally.

Verification
REQ-029 MC=5, MP=7, START; core model raises done after 32 cycles -> PROD_LO=35, PROD_HI=0, STATUS=0x2, spm_start high exactly 1 cycle.
REQ-030 MC=MP=0xFFFFFFFF -> PROD_LO=0x00000001, PROD_HI=0xFFFFFFFE; spm_prod_sel high only in CAP_HI cycle.
REQ-031 TIMEOUT=16, done never asserted -> BUSY drops after 16 WAIT cycles, STATUS=0x4, PROD unchanged; with IRQ_EN=1 irq=1 until STATUS write 0x4 -> irq=0.
REQ-032 Write MC=0x1234 and START while BUSY -> both acked, spm_mc unchanged, no second spm_start pulse.
REQ-033 rst asserted in WAIT -> outputs 0 same cycle, STATUS=0 after release, new START runs normally.
REQ-034 MC write 0xAABBCCDD with sel=0b0101 over MC=0 -> MC=0x00BB00DD.
